igbt_scr_sequencer: RTL and testbench



---
 rtl/igbt_scr_pkg.sv | 36 +++
 rtl/igbt_scr_sequencer_us_timer.sv | 41 ++++
 rtl/igbt_scr_sequencer.sv | 165 ++++++++++++++++
 tb/tb_igbt_scr_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/igbt_scr_pkg.sv
// Shared types and constants for the IGBT/SCR pulse sequencer.
package igbt_scr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DEAD,
        ST_FAULT
    } state_t;

    localparam logic [1:0] FC_NONE   = 2'd0;
    localparam logic [1:0] FC_CMD    = 2'd1;
    localparam logic [1:0] FC_ABORT  = 2'd2;
    localparam logic [1:0] FC_STATUS = 2'd3;

    localparam logic [2:0] CH_IGBT0   = 3'd0;
    localparam logic [2:0] CH_IGBT1   = 3'd1;
    localparam logic [2:0] CH_IGBT2   = 3'd2;
    localparam logic [2:0] CH_IGBT3   = 3'd3;
    localparam logic [2:0] CH_IGBT4   = 3'd4;
    localparam logic [2:0] CH_SCR0    = 3'd5;
    localparam logic [2:0] CH_SCR1    = 3'd6;
    localparam logic [2:0] CH_ILLEGAL = 3'd7;

    localparam int unsigned NUM_IGBT = 5;
    localparam int unsigned NUM_SCR  = 2;

    // Enable pattern {SCR[1:0], IGBT[4:0]} for a channel; illegal channel gives all-off.
    function automatic logic [NUM_SCR+NUM_IGBT-1:0] chan_onehot(input logic [2:0] ch);
        logic [NUM_SCR+NUM_IGBT-1:0] oh;
        oh = '0;
        if (ch != CH_ILLEGAL) oh[ch] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/igbt_scr_sequencer_us_timer.sv
// Prescaler plus loadable 16-bit microsecond down-counter; o_expire marks the
// last cycle of the loaded interval. Shared by on-time and dead-time phases.
module us_timer
    import igbt_scr_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 50
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        i_load,
    input  logic [15:0] i_load_us,
    input  logic        i_en,
    output logic        o_expire
);

    localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);

    logic [PW-1:0] r_pre;
    logic [15:0]   r_us;
    logic          w_wrap;

    assign w_wrap   = i_en && (r_pre == PRE_LAST);
    assign o_expire = w_wrap && (r_us == 16'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pre <= '0;
            r_us  <= '0;
        end else if (i_load) begin
            r_pre <= '0;
            r_us  <= i_load_us;
        end else if (w_wrap) begin
            r_pre <= '0;
            if (r_us != '0) r_us <= r_us - 16'd1;
        end else if (i_en) begin
            r_pre <= r_pre + PW'(1);
        end
    end

endmodule

// File: rtl/igbt_scr_sequencer.sv
// Command-driven IGBT/SCR pulse sequencer with enforced dead time and fault latch.
// Define SEQ_STATUS_CHECK_EN to check driver status feedback against the enables.
module igbt_scr_sequencer
    import igbt_scr_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 50,
    parameter int unsigned DEAD_US    = 2,
    parameter int unsigned MAX_ON_US  = 10000,
    parameter int unsigned STATUS_TMO = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_chan,
    input  logic [15:0]         cmd_on_us,
    input  logic                abort,
    input  logic                fault_clr,
    input  logic [NUM_IGBT-1:0] IGBT_status,
    input  logic [NUM_SCR-1:0]  SCR_status,
    output logic [NUM_IGBT-1:0] IGBT_on_EN,
    output logic [NUM_SCR-1:0]  SCR_on_EN,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [1:0]          fault_code
);

    localparam int unsigned NCH = NUM_IGBT + NUM_SCR;

    state_t          r_state, w_next;
    logic [2:0]      r_chan, w_chan_next;
    logic            r_nodone, w_nodone_next;
    logic [NCH-1:0]  r_en;
    logic            r_cmd_ready, r_busy, r_done, r_fault;
    logic [1:0]      r_fault_code, w_fc_next;
    logic            w_done_next;
    logic            w_accept, w_cmd_ok, w_mismatch;
    logic            w_tmr_load, w_tmr_en, w_tmr_expire;
    logic [15:0]     w_tmr_val;

    assign w_accept = (r_state == ST_IDLE) && cmd_valid && r_cmd_ready && !abort;
    assign w_cmd_ok = (cmd_chan != CH_ILLEGAL) && (cmd_on_us != 16'd0) &&
                      (cmd_on_us <= 16'(MAX_ON_US));
    assign w_tmr_en = (r_state == ST_DRIVE) || (r_state == ST_DEAD);

    us_timer #(.CLK_PER_US(CLK_PER_US)) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_load    (w_tmr_load),
        .i_load_us (w_tmr_val),
        .i_en      (w_tmr_en),
        .o_expire  (w_tmr_expire)
    );

`ifdef SEQ_STATUS_CHECK_EN
    localparam int unsigned SW = (STATUS_TMO > 1) ? $clog2(STATUS_TMO + 1) : 1;
    logic [SW-1:0] r_st_wait;

    // r_en already holds the expected feedback pattern: one-hot in DRIVE, zero in DEAD.
    assign w_mismatch = w_tmr_en && (r_st_wait == '0) && ({SCR_status, IGBT_status} != r_en);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)               r_st_wait <= '0;
        else if (w_next != r_state)   r_st_wait <= SW'(STATUS_TMO - 1);
        else if (r_st_wait != '0)     r_st_wait <= r_st_wait - SW'(1);
    end
`else
    logic w_unused_status;
    assign w_unused_status = ^{IGBT_status, SCR_status};
    assign w_mismatch      = 1'b0;
`endif

    always_comb begin
        w_next        = r_state;
        w_chan_next   = r_chan;
        w_nodone_next = r_nodone;
        w_fc_next     = r_fault_code;
        w_done_next   = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_val     = 16'(DEAD_US);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_cmd_ok) begin
                        w_next      = ST_DRIVE;
                        w_chan_next = cmd_chan;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = cmd_on_us;
                    end else begin
                        w_next    = ST_FAULT;
                        w_fc_next = FC_CMD;
                    end
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    w_next    = ST_FAULT;
                    w_fc_next = FC_ABORT;
                end else if (w_mismatch) begin
                    w_next    = ST_FAULT;
                    w_fc_next = FC_STATUS;
                end else if (w_tmr_expire) begin
                    w_next        = ST_DEAD;
                    w_nodone_next = 1'b0;
                    w_tmr_load    = 1'b1;
                end
            end
            ST_DEAD: begin
                if (abort) begin
                    w_next    = ST_FAULT;
                    w_fc_next = FC_ABORT;
                end else if (w_mismatch) begin
                    w_next    = ST_FAULT;
                    w_fc_next = FC_STATUS;
                end else if (w_tmr_expire) begin
                    w_next      = ST_IDLE;
                    w_done_next = !r_nodone;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !abort) begin
                    w_next        = ST_DEAD;
                    w_fc_next     = FC_NONE;
                    w_nodone_next = 1'b1;
                    w_tmr_load    = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= ST_IDLE;
            r_chan       <= CH_IGBT0;
            r_nodone     <= 1'b0;
            r_en         <= '0;
            r_cmd_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            r_state      <= w_next;
            r_chan       <= w_chan_next;
            r_nodone     <= w_nodone_next;
            r_en         <= (w_next == ST_DRIVE) ? chan_onehot(w_chan_next) : '0;
            r_cmd_ready  <= (w_next == ST_IDLE) && !abort;
            r_busy       <= (w_next != ST_IDLE);
            r_done       <= w_done_next;
            r_fault      <= (w_next == ST_FAULT);
            r_fault_code <= w_fc_next;
        end
    end

    assign IGBT_on_EN = r_en[NUM_IGBT-1:0];
    assign SCR_on_EN  = r_en[NCH-1:NUM_IGBT];
    assign cmd_ready  = r_cmd_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule

// File: tb/tb_igbt_scr_sequencer.sv
// Directed self-checking bench for igbt_scr_sequencer (50 cycles/us, 2 us dead time).
module tb_igbt_scr_sequencer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_chan = 3'd0;
    logic [15:0] cmd_on_us = 16'd0;
    logic        abort = 1'b0;
    logic        fault_clr = 1'b0;
    logic [4:0]  IGBT_status;
    logic [1:0]  SCR_status;
    logic [4:0]  IGBT_on_EN;
    logic [1:0]  SCR_on_EN;
    logic        busy, done, fault;
    logic [1:0]  fault_code;

    int unsigned tests = 0;
    int unsigned failed = 0;
    int unsigned mutex_viol = 0;
    logic        status_force0 = 1'b0;

    // Driver model: status follows the enables unless forced low.
    assign IGBT_status = status_force0 ? 5'b0 : IGBT_on_EN;
    assign SCR_status  = status_force0 ? 2'b0 : SCR_on_EN;

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk)
        if ($countones({SCR_on_EN, IGBT_on_EN}) > 1) mutex_viol++;

    igbt_scr_sequencer #(
        .CLK_PER_US (50),
        .DEAD_US    (2),
        .MAX_ON_US  (10000),
        .STATUS_TMO (4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_chan    (cmd_chan),
        .cmd_on_us   (cmd_on_us),
        .abort       (abort),
        .fault_clr   (fault_clr),
        .IGBT_status (IGBT_status),
        .SCR_status  (SCR_status),
        .IGBT_on_EN  (IGBT_on_EN),
        .SCR_on_EN   (SCR_on_EN),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Present a command once cmd_ready is seen; returns just after the accepting edge.
    task automatic issue(input logic [2:0] ch, input logic [15:0] us);
        int unsigned n = 0;
        while (!cmd_ready && n < 1000) begin
            step();
            n++;
        end
        if (!cmd_ready) begin
            tests++;
            failed++;
            $display("FAIL issue_wait_ready: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
        cmd_valid = 1'b1;
        cmd_chan  = ch;
        cmd_on_us = us;
        step();
        cmd_valid = 1'b0;
    endtask

    // Measure on-cycles with the given enable pattern, then all-off cycles until done.
    task automatic measure(input logic [6:0] mask, output int unsigned hi,
                           output int unsigned dead, output logic done_seen,
                           output int unsigned stray);
        hi = 0; dead = 0; stray = 0;
        while ({SCR_on_EN, IGBT_on_EN} == mask && hi < 20000) begin
            hi++;
            step();
        end
        while (!done && dead < 20000) begin
            if ({SCR_on_EN, IGBT_on_EN} != 7'd0) stray++;
            dead++;
            step();
        end
        done_seen = done;
    endtask

    // Pulse fault_clr for one cycle, then count cycles until cmd_ready returns.
    task automatic clear_and_wait(output int unsigned cnt, output logic saw_done);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        cnt = 0;
        saw_done = 1'b0;
        while (!cmd_ready && cnt < 1000) begin
            step();
            cnt++;
            if (done) saw_done = 1'b1;
        end
    endtask

    task automatic test_reset();
        step();
        tests++;
        if ({SCR_on_EN, IGBT_on_EN, cmd_ready, busy, done, fault, fault_code} !== 13'd0) begin
            failed++;
            $display("FAIL reset_outputs: got %b, required all zero", {SCR_on_EN, IGBT_on_EN, cmd_ready, busy, done, fault, fault_code});
        end
        sys_rst_n = 1'b1;
        step();
        tests++;
        if (cmd_ready !== 1'b1) begin failed++; $display("FAIL reset_release_ready: got %b, required 1", cmd_ready); end
        tests++;
        if (busy !== 1'b0 || fault !== 1'b0) begin failed++; $display("FAIL reset_release_idle: busy=%b fault=%b, required 0 0", busy, fault); end
    endtask

    task automatic test_normal();
        int unsigned hi, dead, stray;
        logic d;
        issue(3'd2, 16'd3);
        tests++;
        if (busy !== 1'b1) begin failed++; $display("FAIL normal_busy: got %b, required 1", busy); end
        measure(7'b0000100, hi, dead, d, stray);
        tests++;
        if (hi != 150) begin failed++; $display("FAIL normal_on_cycles: got %0d, required 150", hi); end
        tests++;
        if (dead != 100) begin failed++; $display("FAIL normal_dead_cycles: got %0d, required 100", dead); end
        tests++;
        if (d !== 1'b1 || cmd_ready !== 1'b1) begin failed++; $display("FAIL normal_done_ready: done=%b ready=%b, required 1 1", d, cmd_ready); end
        tests++;
        if (stray != 0) begin failed++; $display("FAIL normal_stray_enable: got %0d, required 0", stray); end
        step();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL normal_done_width: done=%b busy=%b, required 0 0", done, busy); end
    endtask

    task automatic test_min_pulse();
        int unsigned hi, dead, stray;
        logic d;
        issue(3'd5, 16'd1);
        measure(7'b0100000, hi, dead, d, stray);
        tests++;
        if (hi != 50 || dead != 100 || d !== 1'b1) begin
            failed++;
            $display("FAIL min_pulse: hi=%0d dead=%0d done=%b, required 50 100 1", hi, dead, d);
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  chs [3] = '{3'd7, 3'd0, 3'd1};
        logic [15:0] uss [3] = '{16'd5, 16'd0, 16'd10001};
        int unsigned cnt;
        logic sd;
        for (int unsigned i = 0; i < 3; i++) begin
            issue(chs[i], uss[i]);
            tests++;
            if (fault !== 1'b1 || fault_code !== 2'd1) begin
                failed++;
                $display("FAIL illegal_fault[%0d]: fault=%b code=%0d, required 1 1", i, fault, fault_code);
            end
            tests++;
            if ({SCR_on_EN, IGBT_on_EN} !== 7'd0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                failed++;
                $display("FAIL illegal_outputs[%0d]: en=%b ready=%b busy=%b, required 0 0 1", i, {SCR_on_EN, IGBT_on_EN}, cmd_ready, busy);
            end
            step(); step();
            clear_and_wait(cnt, sd);
            tests++;
            if (cnt != 100 || sd !== 1'b0) begin
                failed++;
                $display("FAIL illegal_recover[%0d]: cycles=%0d done=%b, required 100 0", i, cnt, sd);
            end
            tests++;
            if (fault !== 1'b0 || fault_code !== 2'd0) begin
                failed++;
                $display("FAIL illegal_cleared[%0d]: fault=%b code=%0d, required 0 0", i, fault, fault_code);
            end
        end
    endtask

    task automatic test_abort();
        int unsigned cnt;
        logic sd;
        issue(3'd6, 16'd10);
        for (int unsigned i = 0; i < 199; i++) step();
        tests++;
        if (SCR_on_EN !== 2'b10) begin failed++; $display("FAIL abort_pre_enable: got %b, required 10", SCR_on_EN); end
        abort = 1'b1;
        step();
        tests++;
        if (SCR_on_EN !== 2'b00 || IGBT_on_EN !== 5'd0) begin failed++; $display("FAIL abort_enable_drop: got %b, required 0", {SCR_on_EN, IGBT_on_EN}); end
        tests++;
        if (fault !== 1'b1 || fault_code !== 2'd2) begin failed++; $display("FAIL abort_code: fault=%b code=%0d, required 1 2", fault, fault_code); end
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        step();
        tests++;
        if (fault !== 1'b1 || fault_code !== 2'd2) begin failed++; $display("FAIL abort_clr_ignored: fault=%b code=%0d, required 1 2", fault, fault_code); end
        abort = 1'b0;
        step();
        clear_and_wait(cnt, sd);
        tests++;
        if (cnt != 100) begin failed++; $display("FAIL abort_dead_cycles: got %0d, required 100", cnt); end
        tests++;
        if (sd !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL abort_no_done: got %b, required 0", sd | done); end
    endtask

    task automatic test_idle_abort();
        abort = 1'b1;
        step();
        tests++;
        if (cmd_ready !== 1'b0 || fault !== 1'b0) begin failed++; $display("FAIL idle_abort: ready=%b fault=%b, required 0 0", cmd_ready, fault); end
        abort = 1'b0;
        step();
        tests++;
        if (cmd_ready !== 1'b1) begin failed++; $display("FAIL idle_abort_release: ready=%b, required 1", cmd_ready); end
    endtask

    task automatic test_back_to_back();
        int unsigned cyc = 0, hi1 = 0, done_cyc = 0, hi, dead, stray;
        logic d;
        cmd_valid = 1'b1;
        cmd_chan  = 3'd1;
        cmd_on_us = 16'd2;
        step();
        cmd_chan  = 3'd5;
        cmd_on_us = 16'd1;
        while (SCR_on_EN != 2'b01 && cyc < 1000) begin
            if (IGBT_on_EN == 5'b00010) hi1++;
            if (done) done_cyc = cyc;
            step();
            cyc++;
        end
        cmd_valid = 1'b0;
        tests++;
        if (cyc != 201) begin failed++; $display("FAIL b2b_spacing: got %0d, required 201", cyc); end
        tests++;
        if (hi1 != 100) begin failed++; $display("FAIL b2b_first_on: got %0d, required 100", hi1); end
        tests++;
        if (done_cyc != 200) begin failed++; $display("FAIL b2b_done_cycle: got %0d, required 200", done_cyc); end
        measure(7'b0100000, hi, dead, d, stray);
        tests++;
        if (hi != 50 || dead != 100 || d !== 1'b1) begin failed++; $display("FAIL b2b_second: hi=%0d dead=%0d done=%b, required 50 100 1", hi, dead, d); end
    endtask

    task automatic test_status();
        int unsigned hi, dead, stray, cnt;
        logic d, sd;
        status_force0 = 1'b1;
        issue(3'd0, 16'd2);
`ifdef SEQ_STATUS_CHECK_EN
        step(); step(); step();
        tests++;
        if (fault !== 1'b0 || IGBT_on_EN !== 5'b00001) begin failed++; $display("FAIL status_before_tmo: fault=%b en=%b, required 0 00001", fault, IGBT_on_EN); end
        step();
        tests++;
        if (fault !== 1'b1 || fault_code !== 2'd3 || IGBT_on_EN !== 5'd0) begin
            failed++;
            $display("FAIL status_mismatch: fault=%b code=%0d en=%b, required 1 3 0", fault, fault_code, IGBT_on_EN);
        end
        clear_and_wait(cnt, sd);
        tests++;
        if (cnt != 100) begin failed++; $display("FAIL status_recover: got %0d, required 100", cnt); end
        hi = 0; dead = 0; stray = 0; d = 1'b0;
`else
        cnt = 0; sd = 1'b0;
        measure(7'b0000001, hi, dead, d, stray);
        tests++;
        if (hi != 100 || dead != 100 || d !== 1'b1 || fault !== 1'b0) begin
            failed++;
            $display("FAIL status_ignored: hi=%0d dead=%0d done=%b fault=%b, required 100 100 1 0", hi, dead, d, fault);
        end
`endif
        status_force0 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        issue(3'd3, 16'd5);
        for (int unsigned i = 0; i < 49; i++) step();
        tests++;
        if (IGBT_on_EN !== 5'b01000) begin failed++; $display("FAIL rstmid_pre_enable: got %b, required 01000", IGBT_on_EN); end
        #2 sys_rst_n = 1'b0;
        #1;
        tests++;
        if ({SCR_on_EN, IGBT_on_EN} !== 7'd0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            failed++;
            $display("FAIL rstmid_async_drop: en=%b busy=%b ready=%b, required 0 0 0", {SCR_on_EN, IGBT_on_EN}, busy, cmd_ready);
        end
        step(); step();
        sys_rst_n = 1'b1;
        step();
        tests++;
        if (cmd_ready !== 1'b1 || fault !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("FAIL rstmid_idle: ready=%b fault=%b busy=%b done=%b, required 1 0 0 0", cmd_ready, fault, busy, done);
        end
    endtask

    task automatic test_mutex();
        tests++;
        if (mutex_viol != 0) begin failed++; $display("FAIL mutex: got %0d multi-enable cycles, required 0", mutex_viol); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_min_pulse();
        test_illegal();
        test_abort();
        test_idle_abort();
        test_back_to_back();
        test_status();
        test_reset_mid();
        test_mutex();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
